ldpc_iter_sched: RTL and testbench
==================================

# ldpc_iter_sched

Iteration scheduler for the small LDPC decoder. On `start`, it sequences the check-node unit (CNU) over every parity-check row, then runs one variable-node update (VNU) pass, then evaluates the syndrome. It repeats until the syndrome clears or the iteration budget runs out. It sits between the host control interface and the CNU/VNU datapath, and owns only sequencing: no message data passes through it.

## Interface
- `NUM_ROWS`, default 4: number of parity-check rows per iteration; must be ≥1.
- `ROW_W`, default 2: `row_addr` width; must satisfy 2^ROW_W ≥ NUM_ROWS.
- `ITER_W`, default 5: width of `max_iter` and `iter_cnt`.
- `clock`, in, 1: clock; all logic on the rising edge.
- `reset`, in, 1: reset, synchronous, active-low.
- `start`, in, 1: begin decode; sampled only in IDLE.
- `max_iter`, in, ITER_W: iteration budget; latched on an accepted `start`.
- `cnu_req`, out, 1: CNU request for row `row_addr`.
- `cnu_ack`, in, 1: CNU accepted the current row.
- `row_addr`, out, ROW_W: current check row.
- `vnu_req`, out, 1: VNU pass request.
- `vnu_ack`, in, 1: VNU pass complete.
- `syn_vld`, in, 1: syndrome result valid.
- `syn_ok`, in, 1: syndrome all-zero; meaningful only with `syn_vld`.
- `busy`, out, 1: high from an accepted `start` until `done`.
- `done`, out, 1: single-cycle completion pulse.
- `converged`, out, 1: result flag; holds until the next accepted `start`.
- `iter_cnt`, out, ITER_W: iterations completed; holds until the next accepted `start`.

## Operation
- States: IDLE, CHK, VAR, SYN, FIN.
- **IDLE.** All requests are low. `start`=1 latches `max_iter` and clears `iter_cnt`, `converged` and `row_addr`.
  - If `max_iter`≠0: go to CHK.
  - If `max_iter`=0: go to FIN with `converged`=0 and `iter_cnt`=0; no requests are issued.
- **CHK.** `cnu_req`=1 with `row_addr`.
  - A row is accepted on any cycle where `cnu_req` and `cnu_ack` are both 1.
  - On accept with `row_addr`<NUM_ROWS-1: `row_addr` increments and `cnu_req` stays high, allowing back-to-back rows.
  - On accept of the last row: `row_addr` returns to 0 and the block goes to VAR.
- **VAR.** `vnu_req`=1 until `vnu_ack`=1, then go to SYN.
- **SYN.** Wait for `syn_vld`=1. Then `iter_cnt` increments and:
  - `syn_ok`=1: `converged`=1, go to FIN (early termination).
  - Otherwise, if `iter_cnt`+1 = latched `max_iter`: `converged`=0, go to FIN.
  - Otherwise: go to CHK at row 0.
- **FIN.** `done`=1 and `busy`=0 for this one cycle, then go to IDLE.
- Boundary conditions:
  - `start` while not in IDLE is ignored.
  - An `ack` without a matching `req` is ignored.
  - `syn_vld` outside SYN is ignored.
  - `start` asserted in the same cycle as the FIN→IDLE transition is not accepted; it is seen on the next cycle.
- `iter_cnt` never exceeds the latched `max_iter`, so it never wraps.
- Reset (`reset`=0 at an edge, including mid-decode): state→IDLE. `cnu_req`, `vnu_req`, `busy`, `done`, `converged`, `iter_cnt` and `row_addr` all become 0 on that edge.

## Timing
- All outputs are registered.
- `start` accepted at edge T:
  - `busy`=1 and `cnu_req`=1 with `row_addr`=0 from T+1.
  - With `max_iter`=0: `done`=1 during T+1 instead.
- A row accepted at edge E: the next row is presented from E+1.
- Last-row accept at edge E: `vnu_req`=1 from E+1.
- `vnu_ack` at edge E: SYN from E+1.
- `syn_vld` at edge E:
  - Terminating: `done`=1 during E+1, with `converged` and `iter_cnt` already valid during that cycle.
  - Not terminating: `cnu_req` rises at E+1.
- With zero-wait acks, an iteration is NUM_ROWS+2 cycles plus the `syn_vld` wait.

## Configuration
- `LDPC_SCHED_EARLY_TERM_EN` defined: `syn_ok`=1 in SYN terminates early, as described in Operation.
- Not defined:
  - `syn_ok` is ignored for termination, and exactly `max_iter` iterations always run.
  - `converged` is loaded with `syn_ok` sampled at the final `syn_vld`.
  - SYN still waits for `syn_vld` on every iteration.

## Structure
- Shared package `ldpc_pkg` holds:
  - the state enum `sched_state_t` (IDLE, CHK, VAR, SYN, FIN);
  - default widths `LDPC_ROW_W` and `LDPC_ITER_W`, reused by the CNU and VNU.
- No sub-module: the row and iteration counters are small and live inline with the FSM in `ldpc_iter_sched`.

## Test plan
All scenarios use NUM_ROWS=4.
- **Zero-wait, early termination** (EN defined): `max_iter`=8, `cnu_ack`/`vnu_ack` tied to 1, `syn_ok`=1 on the 2nd `syn_vld` → row_addr sequence 0,1,2,3 twice; `done` pulse with `converged`=1 and `iter_cnt`=2.
- **Budget exhausted:** `max_iter`=3, `syn_ok`=0 always → exactly 12 CNU accepts and 3 VNU accepts; `done` with `converged`=0 and `iter_cnt`=3.
- **Zero budget:** `max_iter`=0 → `done` one cycle after `start`; no `cnu_req`/`vnu_req`; `iter_cnt`=0.
- **Stalled acks:** `cnu_ack` held low 3 cycles on row 2 → `cnu_req`=1 and `row_addr`=2 held stable throughout; the row count is still 4 per iteration.
- **Reset mid-decode:** `reset`=0 while in VAR → next edge all outputs 0 and state IDLE; a following `start` begins again at row 0 with `iter_cnt`=0.
- **Early-termination compiled out:** `max_iter`=4, `syn_ok`=1 every iteration → 4 full iterations; `converged`=1 and `iter_cnt`=4.

Source files
------------

// File: rtl/ldpc_iter_sched_pkg.sv
// Shared LDPC decoder definitions: scheduler state encoding and default
// widths used by the scheduler, CNU and VNU.
package ldpc_pkg;

  localparam int LDPC_ROW_W  = 2;
  localparam int LDPC_ITER_W = 5;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    VAR,
    SYN,
    FIN
  } sched_state_t;

endpackage

// File: rtl/ldpc_iter_sched_if.sv
// Scheduler <-> CNU/VNU/syndrome handshake bundle. The scheduler drives the
// master side; the datapath drives the slave side.
interface ldpc_iter_sched_if
  import ldpc_pkg::*;
#(
  parameter int ROW_W = LDPC_ROW_W
);

  logic             cnu_req;
  logic             cnu_ack;
  logic [ROW_W-1:0] row_addr;
  logic             vnu_req;
  logic             vnu_ack;
  logic             syn_vld;
  logic             syn_ok;

  modport master (
    output cnu_req,
    output row_addr,
    output vnu_req,
    input  cnu_ack,
    input  vnu_ack,
    input  syn_vld,
    input  syn_ok
  );

  modport slave (
    input  cnu_req,
    input  row_addr,
    input  vnu_req,
    output cnu_ack,
    output vnu_ack,
    output syn_vld,
    output syn_ok
  );

endinterface

// File: rtl/ldpc_iter_sched.sv
// LDPC iteration scheduler: CNU over all rows, one VNU pass, syndrome check,
// repeat. Early termination on syn_ok is enabled by LDPC_SCHED_EARLY_TERM_EN.
module ldpc_iter_sched
  import ldpc_pkg::*;
#(
  parameter int NUM_ROWS = 4,
  parameter int ROW_W    = LDPC_ROW_W,
  parameter int ITER_W   = LDPC_ITER_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ITER_W-1:0]     max_iter,
  ldpc_iter_sched_if.master     dp,
  output logic                  busy,
  output logic                  done,
  output logic                  converged,
  output logic [ITER_W-1:0]     iter_cnt
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  sched_state_t      state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] max_q, max_d;
  logic [ITER_W-1:0] iter_inc;
  logic              conv_q, conv_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnu_req_q, cnu_req_d;
  logic              vnu_req_q, vnu_req_d;

  assign iter_inc = iter_q + ITER_W'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      iter_q    <= '0;
      max_q     <= '0;
      conv_q    <= '0;
      busy_q    <= '0;
      done_q    <= '0;
      cnu_req_q <= '0;
      vnu_req_q <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      iter_q    <= iter_d;
      max_q     <= max_d;
      conv_q    <= conv_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cnu_req_q <= cnu_req_d;
      vnu_req_q <= vnu_req_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    iter_d  = iter_q;
    max_d   = max_q;
    conv_d  = conv_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          max_d   = max_iter;
          iter_d  = '0;
          conv_d  = 1'b0;
          row_d   = '0;
          state_d = (max_iter != '0) ? CHK : FIN;
        end
      end
      CHK: begin
        // cnu_req is high for the whole of CHK, so ack alone marks an accept
        if (dp.cnu_ack) begin
          if (row_q == LAST_ROW) begin
            row_d   = '0;
            state_d = VAR;
          end else begin
            row_d = row_q + ROW_W'(1);
          end
        end
      end
      VAR: begin
        if (dp.vnu_ack) state_d = SYN;
      end
      SYN: begin
        if (dp.syn_vld) begin
          iter_d = iter_inc;
`ifdef LDPC_SCHED_EARLY_TERM_EN
          if (dp.syn_ok) begin
            conv_d  = 1'b1;
            state_d = FIN;
          end else if (iter_inc == max_q) begin
            conv_d  = 1'b0;
            state_d = FIN;
          end else begin
            state_d = CHK;
          end
`else
          if (iter_inc == max_q) begin
            conv_d  = dp.syn_ok;
            state_d = FIN;
          end else begin
            state_d = CHK;
          end
`endif
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they can be registered
    // without adding a cycle of latency.
    cnu_req_d = (state_d == CHK);
    vnu_req_d = (state_d == VAR);
    busy_d    = (state_d == CHK) || (state_d == VAR) || (state_d == SYN);
    done_d    = (state_d == FIN);
  end

  assign dp.cnu_req  = cnu_req_q;
  assign dp.vnu_req  = vnu_req_q;
  assign dp.row_addr = row_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;
  assign iter_cnt    = iter_q;

endmodule

// File: tb/tb_ldpc_iter_sched.sv
// Self-checking bench for ldpc_iter_sched against a decode-level reference model.
module tb_ldpc_iter_sched;

  localparam int NR = 4;
  localparam int RW = 2;
  localparam int IW = 5;

`ifdef LDPC_SCHED_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [IW-1:0] max_iter;
  logic          busy;
  logic          done;
  logic          converged;
  logic [IW-1:0] iter_cnt;

  ldpc_iter_sched_if #(.ROW_W(RW)) dp ();

  ldpc_iter_sched #(
    .NUM_ROWS (NR),
    .ROW_W    (RW),
    .ITER_W   (IW)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .max_iter  (max_iter),
    .dp        (dp),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .iter_cnt  (iter_cnt)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  bit ok_pat[32];

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: number of iterations and final converged flag for one decode.
  function automatic void model(input int mx, output int n, output bit conv);
    n    = mx;
    conv = 1'b0;
    if (mx == 0) return;
    if (EARLY) begin
      for (int i = 0; i < mx; i++) begin
        if (ok_pat[i]) begin
          n    = i + 1;
          conv = 1'b1;
          return;
        end
      end
    end else begin
      conv = ok_pat[mx-1];
    end
  endfunction

  task automatic set_ok(input int mode);
    // 0: all zero, 1: all one, 2: random
    for (int i = 0; i < 32; i++)
      ok_pat[i] = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
  endtask

  // mode 0: zero-wait acks and syndrome; 1: random waits and noise; 2: stall row 2
  task automatic run_decode(input int mx, input int mode);
    int n;
    bit conv;
    int cnu_cnt = 0, vnu_cnt = 0, syn_cnt = 0, cyc, stall = 3;
    bit owed = 0, seen_req = 0, pend_c = 0, pend_v = 0;
    int cnt_hold, conv_hold;
    model(mx, n, conv);
    start    = 1'b1;
    max_iter = IW'(mx);
    @(negedge clock);
    start    = 1'b0;
    max_iter = IW'($urandom);
    for (cyc = 1; cyc <= 3000; cyc++) begin
      if (done) break;
      check("busy_run", busy, 1);
      check("iter_cnt_run", iter_cnt, syn_cnt);
      if (pend_c) check("cnu_req_held", dp.cnu_req, 1);
      if (pend_v) check("vnu_req_held", dp.vnu_req, 1);
      if (dp.cnu_req) begin
        seen_req = 1'b1;
        check("row_addr", dp.row_addr, cnu_cnt % NR);
      end
      if (dp.vnu_req) seen_req = 1'b1;
      case (mode)
        0: dp.cnu_ack = 1'b1;
        1: dp.cnu_ack = 1'($urandom_range(0, 2) != 0);
        default: begin
          if (dp.cnu_req && dp.row_addr == 2'd2 && stall > 0) begin
            dp.cnu_ack = 1'b0;
            stall--;
          end else begin
            dp.cnu_ack = 1'b1;
          end
        end
      endcase
      dp.vnu_ack = (mode == 1) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      pend_c = dp.cnu_req && !dp.cnu_ack;
      pend_v = dp.vnu_req && !dp.vnu_ack;
      if (dp.cnu_req && dp.cnu_ack) cnu_cnt++;
      if (owed) begin
        if (mode != 1 || $urandom_range(0, 1) == 1) begin
          dp.syn_vld = 1'b1;
          dp.syn_ok  = ok_pat[syn_cnt];
          syn_cnt++;
          owed = 1'b0;
        end else begin
          dp.syn_vld = 1'b0;
          dp.syn_ok  = 1'($urandom_range(0, 1));
        end
      end else begin
        // stray syndromes outside SYN must be ignored
        dp.syn_vld = (mode == 1) && ($urandom_range(0, 3) == 0);
        dp.syn_ok  = 1'($urandom_range(0, 1));
      end
      if (dp.vnu_req && dp.vnu_ack) begin
        vnu_cnt++;
        owed = 1'b1;
      end
      start    = busy && ($urandom_range(0, 7) == 0);
      max_iter = IW'($urandom);
      @(negedge clock);
    end
    start      = 1'b0;
    dp.cnu_ack = 1'b0;
    dp.vnu_ack = 1'b0;
    dp.syn_vld = 1'b0;
    check("done_seen", done, 1);
    if (mode == 0) check("latency", cyc, 6 * n + 1);
    if (mode == 2) check("latency_stall", cyc, 6 * n + 4);
    check("busy_at_done", busy, 0);
    check("converged", converged, conv);
    check("iter_cnt", iter_cnt, n);
    check("cnu_accepts", cnu_cnt, n * NR);
    check("vnu_accepts", vnu_cnt, n);
    check("syn_count", syn_cnt, n);
    check("req_seen", seen_req, (n > 0) ? 1 : 0);
    cnt_hold  = iter_cnt;
    conv_hold = converged;
    @(negedge clock);
    check("done_pulse", done, 0);
    check("busy_after", busy, 0);
    check("iter_cnt_hold", iter_cnt, cnt_hold);
    check("converged_hold", converged, conv_hold);
    check("cnu_req_idle", dp.cnu_req, 0);
    check("vnu_req_idle", dp.vnu_req, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_converged"}, converged, 0);
    check({tag, "_iter_cnt"}, iter_cnt, 0);
    check({tag, "_cnu_req"}, dp.cnu_req, 0);
    check({tag, "_vnu_req"}, dp.vnu_req, 0);
    check({tag, "_row_addr"}, dp.row_addr, 0);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    max_iter   = '0;
    dp.cnu_ack = 1'b0;
    dp.vnu_ack = 1'b0;
    dp.syn_vld = 1'b0;
    dp.syn_ok  = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);

    // zero-wait, syndrome clean on the second check
    set_ok(0);
    ok_pat[1] = 1'b1;
    run_decode(8, 0);

    // budget exhausted with random waits
    set_ok(0);
    run_decode(3, 1);

    // zero budget
    run_decode(0, 1);

    // stalled CNU ack on row 2
    set_ok(0);
    run_decode(2, 2);

    // reset while in VAR
    start    = 1'b1;
    max_iter = IW'(5);
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 50 && !dp.vnu_req; i++) begin
      dp.cnu_ack = 1'b1;
      @(negedge clock);
    end
    check("reach_var", dp.vnu_req, 1);
    dp.cnu_ack = 1'b0;
    reset      = 1'b0;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    reset = 1'b1;
    set_ok(0);
    run_decode(3, 0);

    // syndrome clean every iteration
    set_ok(1);
    run_decode(4, 0);

    // randomized decodes
    for (int k = 0; k < 12; k++) begin
      set_ok(2);
      run_decode($urandom_range(0, 6), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
